// File: rtl/reg_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_ctrl_pkg
//  Description : Shared CPU constants for the register-dump controller.
//                Holds the default register-file geometry (data width and
//                address width) and the dump FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_ctrl_pkg;

    // Default register-file geometry, shared with the register file and datapath
    localparam int c_size_default    = 16;
    localparam int c_regbits_default = 4;

    // Dump FSM state encoding
    localparam int         c_state_w     = 3;
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_issue    = 3'd1;
    localparam logic [2:0] c_st_wait     = 3'd2;
    localparam logic [2:0] c_st_present  = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_ctrl
//  Description : Read-side initiator for the CPU register file. On start it
//                walks every register address on the second read port,
//                captures each value and streams {index, value} beats to a
//                downstream consumer over valid/ready. While busy it holds
//                off register-file writes so each dump is a coherent snapshot.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-high reset
//                start    - one-cycle dump request, honoured only when idle
//                abort    - cancel the dump in progress
//                busy     - dump in progress
//                done     - one-cycle pulse after the last beat is accepted
//                rfHold   - register-file write hold (same as busy)
//                rfAddr   - address to register-file srcAddr
//                rfData   - register-file readData2 (one cycle after rfAddr)
//                outValid - outData/outAddr hold a captured register
//                outReady - consumer ready
//                outData  - captured register value
//                outAddr  - index of outData
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int SIZE    = c_size_default,
    parameter int REGBITS = c_regbits_default
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               rfHold,
    output logic [REGBITS-1:0] rfAddr,
    input  logic [SIZE-1:0]    rfData,
    output logic               outValid,
    input  logic               outReady,
    output logic [SIZE-1:0]    outData,
    output logic [REGBITS-1:0] outAddr
);

    logic [c_state_w-1:0] r_state;
    logic [REGBITS-1:0]   r_count;
    logic [SIZE-1:0]      r_out_data;
    logic [REGBITS-1:0]   r_out_addr;
    logic                 w_last;

    // Last register is all-ones; the counter is REGBITS wide so the
    // increment after the final beat wraps back to zero on its own.
    assign w_last = (r_count == {REGBITS{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
        end else if (abort) begin
            // Abort outranks both start (in IDLE) and a pending handshake
            // (in PRESENT): the in-flight beat is dropped, no done pulse.
            r_state <= c_st_idle;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_issue;
                        r_count <= '0;
                    end
                end
                c_st_issue: begin
                    // Register file samples rfAddr at this closing edge
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    r_out_data <= rfData;
                    r_out_addr <= r_count;
                    r_state    <= c_st_present;
                end
                c_st_present: begin
                    if (outReady) begin
                        r_count <= r_count + 1'b1;
                        r_state <= w_last ? c_st_done : c_st_issue;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_count <= '0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Every output is a register or a pure state decode, so outReady never
    // reaches an output combinationally.
    assign busy     = (r_state != c_st_idle);
    assign rfHold   = busy;
    assign done     = (r_state == c_st_done);
    assign outValid = (r_state == c_st_present);
    assign rfAddr   = r_count;
    assign outData  = r_out_data;
    assign outAddr  = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_ctrl
//  Description : Self-checking bench for reg_dump_ctrl with a register-file
//                model (one-cycle read latency, writes gated by rfHold) and
//                a snapshot-queue reference model of the dump stream.
//  Ports       : none (testbench)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;
    import reg_dump_ctrl_pkg::*;

    localparam int SIZE    = 16;
    localparam int REGBITS = 4;
    localparam int NREG    = 16;

    logic               clk = 1'b0;
    logic               reset, start, abort, outReady;
    logic               busy, done, rfHold, outValid;
    logic [REGBITS-1:0] rfAddr, outAddr;
    logic [SIZE-1:0]    rfData, outData;

    // Register-file model
    logic [SIZE-1:0]    regs [NREG];
    logic               load, wr_en;
    logic [REGBITS-1:0] wr_addr;
    logic [SIZE-1:0]    wr_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rfData <= regs[rfAddr];
        if (load) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 16'(16'h1000 + i);
        end else if (wr_en && !rfHold) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_dump_ctrl #(.SIZE(SIZE), .REGBITS(REGBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rfHold   (rfHold),
        .rfAddr   (rfAddr),
        .rfData   (rfData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outAddr  (outAddr)
    );

    // Reference model: a dump is the snapshot of all registers taken when
    // start is accepted, delivered in index order, followed by one done.
    typedef struct packed {
        logic [REGBITS-1:0] addr;
        logic [SIZE-1:0]    data;
    } beat_t;

    beat_t q[$];
    bit    m_active, m_in_done;
    int    total, bad, beats_seen, dones_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock with model bookkeeping and per-cycle protocol checks.
    task automatic cycle();
        bit                 hs, last, ab, acc, keep;
        logic [REGBITS-1:0] p_addr;
        logic [SIZE-1:0]    p_data;
        ab   = abort && m_active;
        acc  = start && !abort && !m_active;
        hs   = outValid && outReady && !abort;
        last = 1'b0;
        if (hs) begin
            beats_seen++;
            if (q.size() == 0) begin
                check("extra_beat", 32'd1, 32'd0);
            end else begin
                check("beat_addr", 32'(outAddr), 32'(q[0].addr));
                check("beat_data", 32'(outData), 32'(q[0].data));
                last = (q.size() == 1);
                void'(q.pop_front());
            end
        end
        keep   = outValid && !hs && !abort;
        p_addr = outAddr;
        p_data = outData;
        @(posedge clk);
        #1;
        if (ab) begin
            q.delete();
            m_active  = 1'b0;
            m_in_done = 1'b0;
        end else begin
            if (m_in_done) begin
                m_active  = 1'b0;
                m_in_done = 1'b0;
            end
            if (last) m_in_done = 1'b1;
            if (acc) begin
                m_active = 1'b1;
                q.delete();
                for (int i = 0; i < NREG; i++) q.push_back(beat_t'{4'(i), regs[i]});
            end
        end
        if (done) dones_seen++;
        check("busy", 32'(busy), 32'(m_active));
        check("rfHold", 32'(rfHold), 32'(m_active));
        check("done", 32'(done), 32'(m_in_done));
        if (keep) begin
            check("hold_valid", 32'(outValid), 32'd1);
            check("hold_beat", 32'({outAddr, outData}), 32'({p_addr, p_data}));
        end
        if (outValid) check("valid_has_beat", 32'(q.size() > 0 && !m_in_done), 32'd1);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    typedef struct {
        bit                 s, a, r;
        bit                 e_busy, e_valid, e_done;
        logic [REGBITS-1:0] e_rfaddr;
        bit                 chk_out;
        logic [REGBITS-1:0] e_oaddr;
        logic [SIZE-1:0]    e_odata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  bp_done, rs_done;
        total = 0; bad = 0; beats_seen = 0; dones_seen = 0;
        m_active = 0; m_in_done = 0;
        reset = 1; start = 0; abort = 0; outReady = 0;
        load = 0; wr_en = 0; wr_addr = '0; wr_data = '0;

        //              s  a  r  busy v  d  rfA  chk oA   oD
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[3]  = '{0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 1, 1, 0, 4'd0, 1, 4'd0, 16'h1000};
        vecs[5]  = '{0, 0, 0, 1, 1, 0, 4'd0, 1, 4'd0, 16'h1000};
        vecs[6]  = '{0, 0, 1, 1, 0, 0, 4'd1, 0, 4'd0, 16'h0000};
        vecs[7]  = '{0, 0, 1, 1, 0, 0, 4'd1, 0, 4'd0, 16'h0000};
        vecs[8]  = '{0, 0, 1, 1, 1, 0, 4'd1, 1, 4'd1, 16'h1001};
        vecs[9]  = '{0, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[10] = '{1, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[11] = '{0, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0000};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rfHold", 32'(rfHold), 32'd0);
        check("rst_rfAddr", 32'(rfAddr), 32'd0);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outData", 32'(outData), 32'd0);
        check("rst_outAddr", 32'(outAddr), 32'd0);
        reset = 0;
        load = 1;
        cycle();
        load = 0;

        // Table-driven start-up, backpressure and abort-priority vectors
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].s; abort = vecs[i].a; outReady = vecs[i].r;
            cycle();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_valid", i), 32'(outValid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_rfAddr", i), 32'(rfAddr), 32'(vecs[i].e_rfaddr));
            if (vecs[i].chk_out) begin
                check($sformatf("vec%0d_outAddr", i), 32'(outAddr), 32'(vecs[i].e_oaddr));
                check($sformatf("vec%0d_outData", i), 32'(outData), 32'(vecs[i].e_odata));
            end
        end
        start = 0; abort = 0;
        cycle();

        // Full dump with ready high, exact done timing, suppressed write to r2
        beats_seen = 0; dones_seen = 0;
        outReady = 1; start = 1;
        cycle();
        start = 0;
        n = 1;
        while (!done && n < 200) begin
            if (n == 2) begin wr_en = 1; wr_addr = 4'd2; wr_data = 16'hBEEF; end
            if (n == 3) wr_en = 0;
            cycle();
            n++;
        end
        wr_en = 0;
        check("done_cycle", 32'(n), 32'd49);
        cycle();
        check("busy_after_done", 32'(busy), 32'd0);
        check("full_beats", 32'(beats_seen), 32'd16);
        check("full_dones", 32'(dones_seen), 32'd1);
        check("hold_write_r2", 32'(regs[2]), 32'h1002);

        // Backpressure at beat 3, restart attempt at beat 7
        beats_seen = 0; dones_seen = 0; bp_done = 0; rs_done = 0;
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (!done && n < 300) begin
            if (outValid && outAddr == 4'd3 && !bp_done) begin
                outReady = 0;
                repeat (5) begin
                    cycle();
                    check("bp_valid", 32'(outValid), 32'd1);
                    check("bp_data", 32'(outData), 32'h1003);
                end
                outReady = 1;
                bp_done = 1;
            end
            if (outValid && outAddr == 4'd7 && !rs_done) begin
                start = 1;
                rs_done = 1;
            end
            cycle();
            start = 0;
            n++;
        end
        if (!done) check("bp_timeout", 32'd0, 32'd1);
        cycle();
        check("bp_beats", 32'(beats_seen), 32'd16);
        check("bp_dones", 32'(dones_seen), 32'd1);

        // Abort in PRESENT of beat 5 with ready high
        dones_seen = 0;
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (!(outValid && outAddr == 4'd5) && n < 100) begin cycle(); n++; end
        check("abort_reach_beat5", 32'(outValid && outAddr == 4'd5), 32'd1);
        abort = 1;
        cycle();
        abort = 0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(outValid), 32'd0);
        repeat (3) cycle();
        check("abort_no_done", 32'(dones_seen), 32'd0);
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (!outValid && n < 10) begin cycle(); n++; end
        check("restart_addr", 32'(outAddr), 32'd0);
        run_until_done(100);

        // Reset during WAIT of beat 10
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (!(outValid && outAddr == 4'd9) && n < 100) begin cycle(); n++; end
        cycle();   // handshake beat 9 -> ISSUE beat 10
        cycle();   // -> WAIT beat 10
        #2;
        reset = 1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rfHold", 32'(rfHold), 32'd0);
        check("mid_rst_rfAddr", 32'(rfAddr), 32'd0);
        check("mid_rst_outValid", 32'(outValid), 32'd0);
        check("mid_rst_outData", 32'(outData), 32'd0);
        check("mid_rst_outAddr", 32'(outAddr), 32'd0);
        q.delete(); m_active = 0; m_in_done = 0;
        @(posedge clk);
        #1;
        reset = 0;
        beats_seen = 0; dones_seen = 0;
        start = 1;
        cycle();
        start = 0;
        run_until_done(100);
        check("post_rst_beats", 32'(beats_seen), 32'd16);
        check("post_rst_dones", 32'(dones_seen), 32'd1);

        // Randomized traffic against the snapshot model
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            outReady = ($urandom_range(0, 9) < 6);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 16'($urandom);
            cycle();
        end
        start = 0; abort = 0; outReady = 1; wr_en = 0;
        n = 0;
        while (busy && n < 200) begin cycle(); n++; end
        check("drain_idle", 32'(busy), 32'd0);
        check("drain_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
